// File: rtl/regfile_scoreboard.sv
// GPR file (32 x DATA_W) with write-through bypass and per-register in-flight scoreboard.
// Latency: commit visible from storage next cycle, via bypass same cycle; backpressure: PIPELINE_READY gates commit/issue, issue_stall holds ID.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W+ADDR_W:0]   reg_write_result_bus_i,
   input  logic                     PIPELINE_FLUSH,
   input  logic                     PIPELINE_READY,
   input  logic [ADDR_W-1:0]        rs_addr,
   input  logic [ADDR_W-1:0]        rt_addr,
   output logic [DATA_W-1:0]        rs_data,
   output logic [DATA_W-1:0]        rt_data,
   input  logic                     issue_valid,
   input  logic                     issue_we,
   input  logic [ADDR_W-1:0]        issue_waddr,
   output logic                     rs_pending,
   output logic                     rt_pending,
   output logic                     issue_stall
);

   localparam int NREG = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } wb_bus_t;

   wb_bus_t wb;
   assign wb = wb_bus_t'(reg_write_result_bus_i);

   logic [DATA_W-1:0] regs [NREG];
   logic [CNT_W-1:0]  cnt  [NREG];

   logic bus_wr;
   logic ret;
   logic flush;
   logic iss;

   assign bus_wr = wb.we && (wb.waddr != '0);
   assign ret    = bus_wr && PIPELINE_READY;
   assign flush  = PIPELINE_FLUSH && PIPELINE_READY;
   assign iss    = issue_valid && issue_we && (issue_waddr != '0) && PIPELINE_READY
                   && !issue_stall && !PIPELINE_FLUSH;

   // A bus held while READY=0 never reaches ret, so it retires exactly once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
      end else if (ret) begin
         regs[wb.waddr] <= wb.wdata;
      end
   end

   logic [NREG-1:0] inc_hit;
   logic [NREG-1:0] dec_hit;

   // Decrement of an empty counter is dropped before it can cancel an increment.
   always_comb begin
      inc_hit = '0;
      dec_hit = '0;
      if (iss) inc_hit[issue_waddr] = 1'b1;
      if (ret && (cnt[wb.waddr] != '0)) dec_hit[wb.waddr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (inc_hit[r] && !dec_hit[r])
               cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec_hit[r] && !inc_hit[r])
               cnt[r] <= cnt[r] - CNT_ONE;
         end
      end
   end

   logic rs_bypass;
   logic rt_bypass;

   assign rs_bypass = bus_wr && (wb.waddr == rs_addr);
   assign rt_bypass = bus_wr && (wb.waddr == rt_addr);

   assign rs_data = (rs_addr == '0) ? '0 : (rs_bypass ? wb.wdata : regs[rs_addr]);
   assign rt_data = (rt_addr == '0) ? '0 : (rt_bypass ? wb.wdata : regs[rt_addr]);

   // The write on the bus is resolved by bypass, so it no longer counts as pending.
   assign rs_pending = (rs_addr != '0) &&
                       ((cnt[rs_addr] > CNT_ONE) || ((cnt[rs_addr] == CNT_ONE) && !rs_bypass));
   assign rt_pending = (rt_addr != '0) &&
                       ((cnt[rt_addr] > CNT_ONE) || ((cnt[rt_addr] == CNT_ONE) && !rt_bypass));

   assign issue_stall = issue_valid &&
                        (rs_pending || rt_pending ||
                         (issue_we && (issue_waddr != '0) && (cnt[issue_waddr] == CNT_MAX)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: table of per-cycle stimulus and expected outputs.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [37:0] bus;
   logic        flush, ready;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_data, rt_data;
   logic        issue_valid, issue_we;
   logic [4:0]  issue_waddr;
   logic        rs_pending, rt_pending, issue_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .reg_write_result_bus_i (bus),
      .PIPELINE_FLUSH         (flush),
      .PIPELINE_READY         (ready),
      .rs_addr                (rs_addr),
      .rt_addr                (rt_addr),
      .rs_data                (rs_data),
      .rt_data                (rt_data),
      .issue_valid            (issue_valid),
      .issue_we               (issue_we),
      .issue_waddr            (issue_waddr),
      .rs_pending             (rs_pending),
      .rt_pending             (rt_pending),
      .issue_stall            (issue_stall)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rdy;
      logic        fl;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        iv;
      logic        iwe;
      logic [4:0]  iwa;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic        e_rsp;
      logic        e_rtp;
      logic        e_stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic rdy, logic fl,
                               logic [4:0] rs, logic [4:0] rt, logic iv, logic iwe, logic [4:0] iwa,
                               logic [31:0] e_rs, logic [31:0] e_rt, logic e_rsp, logic e_rtp,
                               logic e_stall);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.fl = fl;
      v.rs = rs; v.rt = rt; v.iv = iv; v.iwe = iwe; v.iwa = iwa;
      v.e_rs = e_rs; v.e_rt = e_rt; v.e_rsp = e_rsp; v.e_rtp = e_rtp; v.e_stall = e_stall;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus         = {v.we, v.wa, v.wd};
      ready       = v.rdy;
      flush       = v.fl;
      rs_addr     = v.rs;
      rt_addr     = v.rt;
      issue_valid = v.iv;
      issue_we    = v.iwe;
      issue_waddr = v.iwa;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(logic [4:0] rs, logic [4:0] rt);
      drive(mk(0, 0, 0, 1, 0, rs, rt, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      //        we wa wd            rdy fl rs  rt  iv iwe iwa   e_rs          e_rt          rsp rtp stall
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 5,  31, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 5, 32'hDEADBEEF, 1, 0, 5,  31, 0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 5,  5,  0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h1234,     1, 0, 0,  0,  0, 0, 0,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0,  1, 1, 0,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0,  1, 0, 0,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 1,  2,  1, 1, 3,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 3,  0,  1, 0, 0,  32'h0,        32'h0,        1, 0, 1));
      vecs.push_back(mk(1, 3, 32'h7,        1, 0, 3,  0,  1, 0, 0,  32'h7,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 3,  3,  0, 0, 0,  32'h7,        32'h7,        0, 0, 0));
      // two in-flight writes to r4, then a bus held through READY=0
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0,  1, 1, 4,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0,  1, 1, 4,  32'h0,        32'h0,        0, 0, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1, 4, 32'h9,     0, 0, 4,  0,  0, 0, 0,  32'h9,        32'h0,        1, 0, 0));
      vecs.push_back(mk(1, 4, 32'h9,        1, 0, 4,  0,  0, 0, 0,  32'h9,        32'h0,        1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 4,  0,  0, 0, 0,  32'h9,        32'h0,        1, 0, 0));
      vecs.push_back(mk(1, 4, 32'h9,        1, 0, 0,  4,  0, 0, 0,  32'h0,        32'h9,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 4,  4,  1, 0, 0,  32'h9,        32'h9,        0, 0, 0));
      // saturate r6, then flush alongside a commit to r6
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 0, 32'h0,     1, 0, 0,  0,  1, 1, 6,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0,  1, 1, 6,  32'h0,        32'h0,        0, 0, 1));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 6,  0,  0, 0, 0,  32'h0,        32'h0,        1, 0, 0));
      vecs.push_back(mk(1, 6, 32'h2,        1, 1, 0,  0,  1, 1, 7,  32'h0,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 6,  7,  0, 0, 0,  32'h2,        32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 6,  7,  1, 1, 6,  32'h2,        32'h0,        0, 0, 0));

      rst_n = 1'b0;
      idle(0, 0);
      tick();
      tick();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #2;
         check($sformatf("row%0d rs_data", i),     rs_data,     vecs[i].e_rs);
         check($sformatf("row%0d rt_data", i),     rt_data,     vecs[i].e_rt);
         check($sformatf("row%0d rs_pending", i),  32'(rs_pending),  32'(vecs[i].e_rsp));
         check($sformatf("row%0d rt_pending", i),  32'(rt_pending),  32'(vecs[i].e_rtp));
         check($sformatf("row%0d issue_stall", i), 32'(issue_stall), 32'(vecs[i].e_stall));
         tick();
      end

      // last row issued to r6; then reset lands with READY=0 mid-operation
      idle(6, 0);
      #2;
      check("pre_reset rs_pending r6", 32'(rs_pending), 32'd1);
      tick();
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      check("sync_reset not yet applied r5", rs_data, 32'hDEADBEEF);
      tick();
      rst_n = 1'b1;
      #1;
      check("post_reset r5", rs_data, 32'h0);
      check("post_reset r3", rt_data, 32'h0);
      rs_addr = 6;
      rt_addr = 4;
      issue_valid = 1'b1;
      #1;
      check("post_reset r6 pending", 32'(rs_pending), 32'd0);
      check("post_reset r4 data", rt_data, 32'h0);
      check("post_reset stall", 32'(issue_stall), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
